// File: rtl/wishbone_ram_slave_pkg.sv
// Shared types for the wishbone RAM slave: bus widths, FSM states,
// latched request bundle.
package wishbone_ram_slave_pkg;

  typedef logic [31:0] WbAddrBus;
  typedef logic [31:0] WbDataBus;
  typedef logic [3:0]  WbSelBus;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } wb_state_e;

  typedef struct packed {
    WbDataBus data;
    WbSelBus  sel;
    logic     we;
    logic     miss;
  } wb_req_t;

  function automatic logic [3:0] wait_init(input int unsigned ws);
    return (ws == 0) ? 4'd0 : 4'(ws - 1);
  endfunction

endpackage

// File: rtl/wb_ram_array.sv
// Single-port word RAM with byte-lane write enables and registered read.
// Contents are intentionally not reset.
module wb_ram_array
  import wishbone_ram_slave_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  re,
  input  WbSelBus               we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  WbDataBus              wdata,
  output WbDataBus              rdata
);

  WbDataBus mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/wishbone_ram_slave.sv
// Wishbone classic RAM slave with programmable wait states.
// Define WB_RAM_SLAVE_ERR_EN to answer out-of-range addresses with err_o.
module wishbone_ram_slave
  import wishbone_ram_slave_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     wishbone_cyc_i,
  input  logic     wishbone_stb_i,
  input  WbAddrBus wishbone_addr_i,
  input  WbDataBus wishbone_data_i,
  input  logic     wishbone_we_i,
  input  WbSelBus  wishbone_sel_i,
  output WbDataBus wishbone_data_o,
  output logic     wishbone_ack_o,
  output logic     wishbone_err_o
);

  localparam logic [3:0] CNT_INIT = wait_init(WAIT_STATES);

  wb_state_e             state;
  logic [3:0]            cnt;
  wb_req_t               lat;
  logic [ADDR_WIDTH-1:0] lat_idx;
  logic                  ack_q;
  logic                  err_q;

  logic                  req;
  logic                  miss_in;
  logic [ADDR_WIDTH-1:0] in_idx;
  logic [ADDR_WIDTH-1:0] ram_idx;
  WbSelBus               ram_we;
  WbDataBus              ram_wdata;
  WbDataBus              ram_rdata;
  logic                  ram_re;
  logic                  unused_bits;

  assign req    = wishbone_cyc_i & wishbone_stb_i;
  assign in_idx = wishbone_addr_i[ADDR_WIDTH+1:2];

`ifdef WB_RAM_SLAVE_ERR_EN
  assign miss_in = wishbone_addr_i[31:ADDR_WIDTH+2]
                != BASE_ADDR[31:ADDR_WIDTH+2];
  assign wishbone_err_o = err_q;
  assign unused_bits = ^wishbone_addr_i[1:0];
`else
  assign miss_in = 1'b0;
  assign wishbone_err_o = 1'b0;
  assign unused_bits = ^{wishbone_addr_i[1:0],
                         wishbone_addr_i[31:ADDR_WIDTH+2],
                         BASE_ADDR, err_q};
`endif

  // Zero-wait writes commit straight from the bus at the sample edge.
  always_comb begin
    ram_idx   = lat_idx;
    ram_wdata = lat.data;
    ram_we    = '0;
    ram_re    = (state == ST_ACK);
    unique case (1'b1)
      (state == ST_IDLE): begin
        ram_idx   = in_idx;
        ram_wdata = wishbone_data_i;
        if (req && wishbone_we_i && !miss_in && WAIT_STATES == 0)
          ram_we = wishbone_sel_i;
      end
      (state == ST_WAIT): begin
        if (wishbone_cyc_i && cnt == '0 && lat.we && !lat.miss)
          ram_we = lat.sel;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      lat     <= '0;
      lat_idx <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (req) begin
            lat.data <= wishbone_data_i;
            lat.sel  <= wishbone_sel_i;
            lat.we   <= wishbone_we_i;
            lat.miss <= miss_in;
            lat_idx  <= in_idx;
            if (WAIT_STATES == 0) begin
              state <= ST_ACK;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (!wishbone_cyc_i) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt == '0) begin
            state <= ST_ACK;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_ACK: begin
          ack_q <= !lat.miss;
          err_q <= lat.miss;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  wb_ram_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .re   (ram_re),
    .we   (ram_we),
    .addr (ram_idx),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  assign wishbone_ack_o  = ack_q;
  assign wishbone_data_o = ack_q ? ram_rdata : '0;

endmodule

// File: tb/tb_wishbone_ram_slave.sv
// Directed bench: two-wait and zero-wait slaves, reset, abort,
// byte lanes and address decode.
module tb_wishbone_ram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] addr, wdata, rdata;
  logic        ack, err;
  logic        cyc0, stb0, we0;
  logic [3:0]  sel0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        ack0, err0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wishbone_ram_slave #(
    .ADDR_WIDTH (10),
    .WAIT_STATES(2),
    .BASE_ADDR  (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wishbone_cyc_i (cyc),
    .wishbone_stb_i (stb),
    .wishbone_addr_i(addr),
    .wishbone_data_i(wdata),
    .wishbone_we_i  (we),
    .wishbone_sel_i (sel),
    .wishbone_data_o(rdata),
    .wishbone_ack_o (ack),
    .wishbone_err_o (err)
  );

  wishbone_ram_slave #(
    .ADDR_WIDTH (10),
    .WAIT_STATES(0),
    .BASE_ADDR  (32'h0)
  ) dut0 (
    .clk            (clk),
    .rst            (rst),
    .wishbone_cyc_i (cyc0),
    .wishbone_stb_i (stb0),
    .wishbone_addr_i(addr0),
    .wishbone_data_i(wdata0),
    .wishbone_we_i  (we0),
    .wishbone_sel_i (sel0),
    .wishbone_data_o(rdata0),
    .wishbone_ack_o (ack0),
    .wishbone_err_o (err0)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transfer on the two-wait slave; expects ack/err 3 edges
  // after the sample edge, then one idle cycle with all outputs low.
  task automatic xfer(input string tag, input logic [31:0] a,
                      input logic [31:0] d, input logic w,
                      input logic [3:0] s, input logic exp_err,
                      input logic [31:0] exp_data);
    int lat;
    logic ga, ge;
    logic [31:0] got;
    lat = -1; ga = 1'b0; ge = 1'b0; got = '0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; addr = a; wdata = d; we = w; sel = s;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (ack || err) begin
        lat = c - 1; ga = ack; ge = err; got = rdata;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'd3);
    check({tag, " ack"}, {31'd0, ga}, {31'd0, !exp_err});
    check({tag, " err"}, {31'd0, ge}, {31'd0, exp_err});
    if (!w) check({tag, " data"}, got, exp_data);
    @(posedge clk); #1;
    check({tag, " ack after"}, {31'd0, ack}, 32'd0);
    check({tag, " err after"}, {31'd0, err}, 32'd0);
    check({tag, " data after"}, rdata, 32'd0);
  endtask

  // Two back-to-back transfers on the zero-wait slave.
  task automatic pair0(input string tag, input logic w,
                       input logic [31:0] a0, input logic [31:0] d0,
                       input logic [31:0] a1, input logic [31:0] d1,
                       input logic [31:0] e0, input logic [31:0] e1);
    @(posedge clk); #1;
    cyc0 = 1'b1; stb0 = 1'b1; we0 = w; sel0 = 4'hF;
    addr0 = a0; wdata0 = d0;
    @(posedge clk); #1;
    check({tag, " ack0 pre"}, {31'd0, ack0}, 32'd0);
    @(posedge clk); #1;
    check({tag, " ack0 #1"}, {31'd0, ack0}, 32'd1);
    if (!w) check({tag, " data #1"}, rdata0, e0);
    addr0 = a1; wdata0 = d1;
    @(posedge clk); #1;
    check({tag, " ack0 gap"}, {31'd0, ack0}, 32'd0);
    check({tag, " data gap"}, rdata0, 32'd0);
    @(posedge clk); #1;
    check({tag, " ack0 #2"}, {31'd0, ack0}, 32'd1);
    if (!w) check({tag, " data #2"}, rdata0, e1);
    cyc0 = 1'b0; stb0 = 1'b0; we0 = 1'b0;
    @(posedge clk); #1;
    check({tag, " ack0 end"}, {31'd0, ack0}, 32'd0);
  endtask

  int n;

  initial begin
    rst = 1'b0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; addr = '0; wdata = '0;
    cyc0 = 1'b0; stb0 = 1'b0; we0 = 1'b0; sel0 = '0;
    addr0 = '0; wdata0 = '0;
    #12;
    check("rst ack", {31'd0, ack}, 32'd0);
    check("rst err", {31'd0, err}, 32'd0);
    check("rst data", rdata, 32'd0);
    check("rst ack0", {31'd0, ack0}, 32'd0);
    check("rst data0", rdata0, 32'd0);
    rst = 1'b1;

    xfer("wr 0x10", 32'h10, 32'hDEADBEEF, 1'b1, 4'hF, 1'b0, 32'h0);
    xfer("rd 0x10", 32'h10, 32'h0, 1'b0, 4'hF, 1'b0, 32'hDEADBEEF);
    xfer("wr lane1", 32'h10, 32'h0000AA00, 1'b1, 4'b0010, 1'b0, 32'h0);
    xfer("rd lane1", 32'h10, 32'h0, 1'b0, 4'h1, 1'b0, 32'hDEADAAEF);
    xfer("wr sel0", 32'h10, 32'hFFFFFFFF, 1'b1, 4'b0000, 1'b0, 32'h0);
    xfer("rd sel0", 32'h10, 32'h0, 1'b0, 4'hF, 1'b0, 32'hDEADAAEF);

    xfer("wr 0x20", 32'h20, 32'hCAFEF00D, 1'b1, 4'hF, 1'b0, 32'h0);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF;
    addr = 32'h20; wdata = 32'h12345678;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    n = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ack || err) n++;
    end
    check("abort no ack", 32'(n), 32'd0);
    xfer("rd after abort", 32'h20, 32'h0, 1'b0, 4'hF, 1'b0, 32'hCAFEF00D);

    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF;
    addr = 32'h10; wdata = 32'h55555555;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("rst wait ack", {31'd0, ack}, 32'd0);
    check("rst wait err", {31'd0, err}, 32'd0);
    check("rst wait data", rdata, 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    #3 rst = 1'b1;
    n = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack || err) n++;
    end
    check("rst wait no ack", 32'(n), 32'd0);
    xfer("rd after rst", 32'h10, 32'h0, 1'b0, 4'hF, 1'b0, 32'hDEADAAEF);

    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; addr = 32'h10;
    repeat (4) @(posedge clk);
    #1;
    check("pre rst ack", {31'd0, ack}, 32'd1);
    check("pre rst data", rdata, 32'hDEADAAEF);
    #2 rst = 1'b0;
    #1;
    check("rst ack drop", {31'd0, ack}, 32'd0);
    check("rst data drop", rdata, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    #3 rst = 1'b1;

    pair0("b2b wr", 1'b1, 32'h0, 32'hA1A2A3A4, 32'h4, 32'hB1B2B3B4,
          32'h0, 32'h0);
    pair0("b2b rd", 1'b0, 32'h0, 32'h0, 32'h4, 32'h0,
          32'hA1A2A3A4, 32'hB1B2B3B4);
    check("err0 idle", {31'd0, err0}, 32'd0);

    xfer("wr word0", 32'h0, 32'h0BADF00D, 1'b1, 4'hF, 1'b0, 32'h0);
`ifdef WB_RAM_SLAVE_ERR_EN
    xfer("miss rd", 32'h1000, 32'h0, 1'b0, 4'hF, 1'b1, 32'h0);
    xfer("miss wr", 32'h1000, 32'hFFFFFFFF, 1'b1, 4'hF, 1'b1, 32'h0);
    xfer("rd word0", 32'h0, 32'h0, 1'b0, 4'hF, 1'b0, 32'h0BADF00D);
`else
    xfer("alias rd", 32'h1000, 32'h0, 1'b0, 4'hF, 1'b0, 32'h0BADF00D);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wishbone_ram_slave.md
WISHBONE_RAM_SLAVE -- requirements
Module: wishbone_ram_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, word-address width; storage is 2^ADDR_WIDTH x 32 bits.
REQ-002 Parameter WAIT_STATES, default 2, range 0..15; number of wait cycles inserted before ack.
REQ-003 Parameter BASE_ADDR, default 32'h0000_0000; slave decode base, aligned to 2^(ADDR_WIDTH+2).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 wishbone_cyc_i  input  1  bus cycle in progress.
REQ-007 wishbone_stb_i  input  1  strobe; request valid when cyc and stb are both high.
REQ-008 wishbone_addr_i  input  32  byte address; bits [ADDR_WIDTH+1:2] index the word.
REQ-009 wishbone_data_i  input  32  write data.
REQ-010 wishbone_we_i  input  1  1 = write, 0 = read.
REQ-011 wishbone_sel_i  input  4  byte lanes; bit n enables data[8n+7:8n].
REQ-012 wishbone_data_o  output  32  read data; valid only while ack is high.
REQ-013 wishbone_ack_o  output  1  one-cycle transfer acknowledge.
REQ-014 wishbone_err_o  output  1  error acknowledge (see Configuration).

Function
REQ-015 FSM states: IDLE, WAIT, ACK; one-hot or binary encoding, implementer's choice.
REQ-016 IDLE: on an edge with cyc&stb high, latch addr, data, we and sel; go to ACK if WAIT_STATES=0, else go to WAIT with the counter loaded to WAIT_STATES-1.
REQ-017 WAIT: decrement counter each cycle; at counter 0 go to ACK.
REQ-018 ACK: drive ack_o=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-019 Latency: request sampled at edge N, ack high during the cycle following edge N+1+WAIT_STATES.
REQ-020 ack_o is never high in two consecutive cycles; back-to-back requests therefore cost 2+WAIT_STATES cycles each.
REQ-021 Write: the memory is updated at the edge that enters ACK, only the lanes whose sel bit is 1; lanes with sel=0 keep their old value.
REQ-022 Read: wishbone_data_o is registered, holds the full 32-bit word regardless of sel, and is valid during ACK; it is 0 in all other cycles.
REQ-023 Abort: if cyc_i goes low while in WAIT, return to IDLE on the next edge, perform no write and assert no ack.
REQ-024 The stb/we/addr/data inputs are ignored outside IDLE, since the latched copies are used.
REQ-025 sel_i=4'b0000 on a write completes with ack and leaves the memory unchanged.

Reset
REQ-026 Reset, asserted asynchronously, forces state IDLE, counter 0, ack_o=0, err_o=0, data_o=0 and clears the latched request registers.
REQ-027 Reset during WAIT or ACK drops the transfer with no write and no ack after release.
REQ-028 Memory contents are not reset.

Configuration
REQ-029 Macro WB_RAM_SLAVE_ERR_EN.
- Defined: a request whose addr[31:ADDR_WIDTH+2] differs from BASE_ADDR goes through the same WAIT timing, then asserts err_o for one cycle instead of ack_o, with no memory write and data_o=0.
- Undefined: the upper address bits are ignored (aliasing), and err_o is tied to 0.

Structure
REQ-030 FSM state encodings and the bus widths (WbAddrBus, WbDataBus, WbSelBus) belong in the shared defines.v package.
REQ-031 Storage is a sub-module wb_ram_array: a synchronous single-port array with a 4-bit byte-write enable and a registered read.

Verification
REQ-032 WAIT_STATES=2, write addr 0x10, data 0xDEADBEEF, sel 4'hF, then read 0x10 -> ack 3 cycles after each request sample, and read data 0xDEADBEEF.
REQ-033 Word 0x10 holds 0xDEADBEEF; write sel 4'b0010, data 0x0000AA00; then read -> 0xDEADAAEF.
REQ-034 WAIT_STATES=0, two back-to-back reads -> ack pattern 1,0,1, and data_o is 0 while ack is 0.
REQ-035 cyc dropped after 1 wait cycle on a write of 0x12345678 to 0x20 -> no ack, and a later read of 0x20 returns the old value.
REQ-036 rst pulsed low mid-WAIT -> ack_o, err_o and data_o go 0 immediately, and the FSM is in IDLE after release.
REQ-037 With WB_RAM_SLAVE_ERR_EN, BASE_ADDR=0, ADDR_WIDTH=10, read 0x0000_1000 -> err_o high one cycle and ack_o stays 0; without the macro, the same access aliases to word 0 and acks.
